// File: rtl/mdu_sequencer_pkg.sv
// Shared settings for the multiply/divide sequencer: op encodings, latency defaults, FSM states.
package mdu_sequencer_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned MUL_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF = 10;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MFHI  = 3'd6,
        OP_MFLO  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_sequencer.sv
// HI/LO multiply-divide unit: computes the result at acceptance, then models the
// fixed mult/div latency with a down-counter before committing to HI/LO.
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            int_exc_req,
    output logic            busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic [XLEN-1:0] rd_data
);

    localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [XLEN-1:0]   phi_q, phi_d, plo_q, plo_d;

    logic                     accept;
    logic signed [2*XLEN-1:0] prod_s;
    logic [2*XLEN-1:0]        prod_u;
    logic [XLEN-1:0]          div_b;
    logic signed [XLEN-1:0]   quo_s, rem_s;
    logic [XLEN-1:0]          quo_u, rem_u;
    logic                     div_zero;

    // Datapath results; the divisor is forced to 1 on zero so no X/undefined quotient appears.
    assign prod_s   = $signed({{XLEN{a[XLEN-1]}}, a}) * $signed({{XLEN{b[XLEN-1]}}, b});
    assign prod_u   = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
    assign div_zero = (b == '0);
    assign div_b    = div_zero ? XLEN'(1) : b;
    assign quo_s    = $signed(a) / $signed(div_b);
    assign rem_s    = $signed(a) % $signed(div_b);
    assign quo_u    = a / div_b;
    assign rem_u    = a % div_b;

    assign accept = start && !int_exc_req && (state_q == ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT: begin
                            phi_d   = prod_s[2*XLEN-1:XLEN];
                            plo_d   = prod_s[XLEN-1:0];
                            cnt_d   = CNT_W'(MUL_CYCLES);
                            state_d = ST_RUN;
                        end
                        OP_MULTU: begin
                            phi_d   = prod_u[2*XLEN-1:XLEN];
                            plo_d   = prod_u[XLEN-1:0];
                            cnt_d   = CNT_W'(MUL_CYCLES);
                            state_d = ST_RUN;
                        end
                        OP_DIV: begin
                            // Divide by zero commits the current HI/LO unchanged.
                            phi_d   = div_zero ? hi_q : XLEN'(rem_s);
                            plo_d   = div_zero ? lo_q : XLEN'(quo_s);
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            state_d = ST_RUN;
                        end
                        OP_DIVU: begin
                            phi_d   = div_zero ? hi_q : rem_u;
                            plo_d   = div_zero ? lo_q : quo_u;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            state_d = ST_RUN;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = phi_q;
                    lo_d    = plo_q;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_comb begin
        rd_data = '0;
        case (op)
            OP_MFHI: rd_data = hi_q;
            OP_MFLO: rd_data = lo_q;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: vector table run back-to-back through a
// scoreboard queue, plus hand-written concurrency, flush, reset and divide-by-zero sequences.
module tb_mdu_sequencer;
    import mdu_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        int_exc_req;
    logic        busy;
    logic [31:0] hi, lo, rd_data;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cycles;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[11];

    mdu_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .int_exc_req(int_exc_req),
        .busy       (busy),
        .hi         (hi),
        .lo         (lo),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Counts busy cycles (bounded) starting at the current negedge, then pops and compares.
    task automatic wait_done(input string name);
        int   n;
        exp_t e;
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            check_int({name, " busy_cycles"}, n, e.cycles);
            check32({name, " hi"}, hi, e.hi);
            check32({name, " lo"}, lo, e.lo);
        end
    endtask

    // Called at a negedge; pulses start for one cycle and waits for completion.
    task automatic issue(input string name, input logic [2:0] o, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] eh, input logic [31:0] el,
                         input int cyc);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        sb_q.push_back('{hi: eh, lo: el, cycles: cyc});
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(name);
    endtask

    initial begin
        int   n;
        exp_t e;

        vecs[0]  = '{OP_MTHI,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h00000000, 0};
        vecs[1]  = '{OP_MTLO,  32'hCAFEF00D, 32'h0,        32'hDEADBEEF, 32'hCAFEF00D, 0};
        vecs[2]  = '{OP_MULT,  32'h00000003, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[3]  = '{OP_MULTU, 32'h00000003, 32'hFFFFFFFE, 32'h00000002, 32'hFFFFFFFA, 5};
        vecs[4]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[5]  = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
        vecs[6]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[7]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[8]  = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};
        vecs[9]  = '{OP_MULT,  32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000, 5};
        vecs[10] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};

        reset       = 1'b1;
        start       = 1'b0;
        op          = OP_MULT;
        a           = '0;
        b           = '0;
        int_exc_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_int("reset busy", int'(busy), 0);
        check32("reset hi", hi, 32'h0);
        check32("reset lo", lo, 32'h0);

        // Table: each op issued in the first cycle busy is low after the previous one.
        for (int i = 0; i < 11; i++) begin
            issue($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].cycles);
        end

        op = OP_MFHI;
        #1 check32("rd_data mfhi", rd_data, 32'h0000000F);
        op = OP_MFLO;
        #1 check32("rd_data mflo", rd_data, 32'h0FFFFFFF);
        op = OP_MULT;
        #1 check32("rd_data other", rd_data, 32'h0);
        @(negedge clk);

        // DIVU in flight: MULT at busy cycle 4 ignored; flush mid-run does not cancel.
        start = 1'b1;
        op    = OP_DIVU;
        a     = 32'd100;
        b     = 32'd7;
        sb_q.push_back('{hi: 32'd2, lo: 32'd14, cycles: 10});
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            n++;
            int_exc_req = (n >= 2 && n < 6);
            if (n == 4) begin
                start = 1'b1;
                op    = OP_MULT;
                a     = 32'd5;
                b     = 32'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start       = 1'b0;
        int_exc_req = 1'b0;
        e = sb_q.pop_front();
        check_int("conc busy_cycles", n, e.cycles);
        check32("conc hi", hi, e.hi);
        check32("conc lo", lo, e.lo);
        @(negedge clk);
        check_int("conc no mult", int'(busy), 0);

        // Flush blocks MTHI and MULT acceptance.
        start       = 1'b1;
        op          = OP_MTHI;
        a           = 32'h11111111;
        int_exc_req = 1'b1;
        @(negedge clk);
        check32("flush mthi hi", hi, 32'd2);
        op = OP_MULT;
        @(negedge clk);
        check_int("flush mult busy", int'(busy), 0);
        start       = 1'b0;
        int_exc_req = 1'b0;

        // Divide by zero keeps HI/LO.
        issue("mthi", OP_MTHI, 32'h01234567, 32'h0, 32'h01234567, 32'd14, 0);
        issue("mtlo", OP_MTLO, 32'h89ABCDEF, 32'h0, 32'h01234567, 32'h89ABCDEF, 0);
        issue("div0", OP_DIV,  32'h00000005, 32'h0, 32'h01234567, 32'h89ABCDEF, 10);
        issue("divu0", OP_DIVU, 32'hFFFFFFFF, 32'h0, 32'h01234567, 32'h89ABCDEF, 10);

        // Reset at busy cycle 2 abandons the MULT.
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd3;
        b     = 32'hFFFFFFFE;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_int("rst busy c1", int'(busy), 1);
        @(negedge clk);
        check_int("rst busy c2", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_int("rst busy after", int'(busy), 0);
        check32("rst hi after", hi, 32'h0);
        check32("rst lo after", lo, 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check32($sformatf("rst hold hi %0d", k), hi, 32'h0);
            check32($sformatf("rst hold lo %0d", k), lo, 32'h0);
            check_int($sformatf("rst hold busy %0d", k), int'(busy), 0);
        end

        // Reset wins over a simultaneous start.
        reset = 1'b1;
        start = 1'b1;
        op    = OP_MTHI;
        a     = 32'h5A5A5A5A;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check32("rst prio hi", hi, 32'h0);
        check_int("rst prio busy", int'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 Parameter MUL_CYCLES, default 5: busy duration for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10: busy duration for DIV/DIVU.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  E-stage MDU instruction valid this cycle.
REQ-006 op  input  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
REQ-007 a  input  32  rs operand, already forwarded.
REQ-008 b  input  32  rt operand, already forwarded.
REQ-009 int_exc_req  input  1  interrupt/exception flush; blocks acceptance of start.
REQ-010 busy  output  1  registered; high while a mult/div is in progress.
REQ-011 hi  output  32  registered HI register.
REQ-012 lo  output  32  registered LO register.
REQ-013 rd_data  output  32  combinational: hi when op=MFHI, lo when op=MFLO, else 0.

Function
REQ-014 States IDLE and RUN, held in one state register; busy = (state==RUN).
REQ-015 start is accepted only when state==IDLE and int_exc_req==0.
- IDLE->RUN on accepted start with op MULT/MULTU/DIV/DIVU.
- Accepted MTHI/MTLO writes a to hi/lo at that edge; state stays IDLE.
- MFHI/MFLO cause no state change.
REQ-016 On acceptance, the block latches the result into pending_hi/pending_lo and loads counter = MUL_CYCLES or DIV_CYCLES.
- MULT: signed 64-bit a*b; MULTU: unsigned.
- DIV/DIVU: lo=quotient, hi=remainder; signed truncates toward zero and the remainder takes the sign of the dividend.
REQ-017 In RUN, counter decrements each edge; at the edge where counter==1, hi/lo take the pending values and state returns to IDLE.
- busy is high for exactly MUL_CYCLES or DIV_CYCLES cycles.
- The new hi/lo are visible in the first cycle busy is low.
REQ-018 start during RUN is ignored; the stall unit guarantees no such issue, and the block does not rely on that guarantee.
REQ-019 int_exc_req asserted during RUN does not cancel the operation; it only blocks new acceptance.
REQ-020 Divide by zero runs the full DIV_CYCLES; hi/lo keep their previous values at completion.
REQ-021 A new start may be accepted in the cycle after busy falls; there are no back-to-back gap cycles beyond that.
REQ-022 An MTHI/MTLO accepted in IDLE followed immediately by MULT reads no hi/lo state, so there is no ordering hazard.

Reset
REQ-023 reset forces state=IDLE, counter=0, busy=0, hi=0, lo=0, pending_hi=0, pending_lo=0 at the next edge.
REQ-024 reset during RUN abandons the operation; no hi/lo update occurs afterward.
REQ-025 reset has priority over start in the same cycle.

Structure
REQ-026 The op encodings and the MUL_CYCLES/DIV_CYCLES defaults reside in the shared settings header.
REQ-027 No sub-module is required; results are computed combinationally at acceptance and held in the pending registers.

Verification
REQ-028 MULT a=3, b=0xFFFFFFFE -> busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-029 MULTU a=3, b=0xFFFFFFFE -> after 5 cycles hi=0x00000002, lo=0xFFFFFFFA.
REQ-030 DIV a=0xFFFFFFF9 (-7), b=2 -> busy for 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1.
REQ-031 Concurrency and flush check:
- DIVU in flight; issue MULT at busy cycle 4 -> MULT is ignored, only DIVU results appear.
- start+MTHI with int_exc_req=1 -> hi is unchanged.
REQ-032 Reset and divide-by-zero check:
- MULT in flight; reset at busy cycle 2 -> busy=0, hi=lo=0 next cycle, and they stay 0 through cycle 6.
- DIV with b=0 -> busy for 10 cycles, hi/lo unchanged.
